// File: rtl/uart_byte_tx_if.sv
// Byte handshake between the cracker controller (master) and the UART transmit stage (slave).
interface uart_byte_tx_if;
    logic       shift_out;
    logic [0:7] out_byte;
    logic       tx_serial;
    logic       tx_done;
    logic       tx_busy;

    modport master (
        output shift_out,
        output out_byte,
        input  tx_serial,
        input  tx_done,
        input  tx_busy
    );

    modport slave (
        input  shift_out,
        input  out_byte,
        output tx_serial,
        output tx_done,
        output tx_busy
    );
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter: one byte per handshake, LSB first, with a one-cycle tx_done pulse
// and a GAP cycle that swallows the controller's post-done bookkeeping cycle.
module uart_byte_tx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input logic         clk,
    input logic         n_rst,
    uart_byte_tx_if.slave bus
);
    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE,
        GAP
    } state_t;

    state_t        state, state_d;
    logic [BW-1:0] baud_cnt, baud_d;
    logic [2:0]    bit_cnt, bit_d;
    logic [0:7]    shift_reg, shift_d;
    logic          serial_q, serial_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_cnt;
        shift_d = shift_reg;

        case (state)
            IDLE: begin
                if (bus.shift_out) begin
                    shift_d = bus.out_byte;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_reg[0:6]};
                    bit_d   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DONE;
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            DONE:    state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the flops line up with the state they describe.
        serial_d = 1'b1;
        done_d   = 1'b0;
        busy_d   = (state_d != IDLE);
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[7];
            DONE:    done_d   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            serial_q  <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_d;
            baud_cnt  <= baud_d;
            bit_cnt   <= bit_d;
            shift_reg <= shift_d;
            serial_q  <= serial_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.tx_serial = serial_q;
    assign bus.tx_done   = done_q;
    assign bus.tx_busy   = busy_q;
endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: fast instance (4 clocks/bit) and a 434 clocks/bit instance.
module tb_uart_byte_tx;
    logic clk = 1'b0;
    logic n_rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    uart_byte_tx_if bus4();
    uart_byte_tx_if bus434();

    uart_byte_tx #(.CLKS_PER_BIT(4)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus4.slave)
    );

    uart_byte_tx #(.CLKS_PER_BIT(434)) dut_slow (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus434.slave)
    );

    // Expected line level c cycles after the load edge (c=1 is the first start-bit cycle).
    function automatic logic exp_line(input logic [7:0] b, input int c, input int cpb);
        if (c >= 1 && c <= cpb) return 1'b0;
        if (c > cpb && c <= 9 * cpb) return b[(c - cpb - 1) / cpb];
        return 1'b1;
    endfunction

    task automatic test_reset();
        logic [2:0] obs;
        bus4.shift_out   = 1'b0;
        bus4.out_byte    = 8'h00;
        bus434.shift_out = 1'b0;
        bus434.out_byte  = 8'h00;
        #1 n_rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        obs = {bus4.tx_serial, bus4.tx_done, bus4.tx_busy};
        n_checks++;
        if (obs !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_hold: serial/done/busy=%b required %b", obs, 3'b100);
        end
        n_rst = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            obs = {bus4.tx_serial, bus4.tx_done, bus4.tx_busy};
            n_checks++;
            if (obs !== 3'b100) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d: serial/done/busy=%b required %b", c, obs, 3'b100);
            end
        end
    endtask

    task automatic test_single_byte();
        logic [2:0] obs, exp;
        int ndone = 0;
        @(posedge clk); #1;
        bus4.shift_out = 1'b1;
        bus4.out_byte  = 8'hA5;
        @(posedge clk); #1;
        bus4.shift_out = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            obs = {bus4.tx_serial, bus4.tx_done, bus4.tx_busy};
            exp = {exp_line(8'hA5, c, 4), 1'(c == 41), 1'(c <= 42)};
            if (obs[1]) ndone++;
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL single_a5 c=%0d: serial/done/busy=%b required %b", c, obs, exp);
            end
        end
        n_checks++;
        if (ndone !== 1) begin
            n_fail++;
            $display("FAIL single_done_count: got %0d required 1", ndone);
        end
    endtask

    task automatic test_held_request();
        logic [2:0] obs, exp;
        int ndone  = 0;
        int done_c = 0;
        @(posedge clk); #1;
        bus4.shift_out = 1'b1;
        bus4.out_byte  = 8'h3C;
        @(posedge clk);
        for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            obs = {bus4.tx_serial, bus4.tx_done, bus4.tx_busy};
            exp = {(c <= 43) ? exp_line(8'h3C, c, 4) : exp_line(8'hFF, c - 43, 4),
                   1'(c == 41 || c == 84),
                   1'(c <= 42 || (c >= 44 && c <= 85))};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL held_frames c=%0d: serial/done/busy=%b required %b", c, obs, exp);
            end
            // Mimic the controller: zero byte during the cycle after done, then the next byte.
            if (obs[1]) begin
                ndone++;
                done_c = c;
            end
            if (done_c > 0 && c == done_c + 1) begin
                bus4.out_byte = 8'h00;
                if (ndone >= 2) bus4.shift_out = 1'b0;
            end
            if (done_c > 0 && c == done_c + 2 && ndone == 1) bus4.out_byte = 8'hFF;
        end
        bus4.shift_out = 1'b0;
        n_checks++;
        if (ndone !== 2) begin
            n_fail++;
            $display("FAIL held_done_count: got %0d required 2", ndone);
        end
    endtask

    task automatic test_mid_frame_inputs();
        logic [2:0] obs, exp;
        int ndone = 0;
        @(posedge clk); #1;
        bus4.shift_out = 1'b1;
        bus4.out_byte  = 8'h81;
        @(posedge clk);
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            obs = {bus4.tx_serial, bus4.tx_done, bus4.tx_busy};
            exp = {exp_line(8'h81, c, 4), 1'(c == 41), 1'(c <= 42)};
            if (obs[1]) ndone++;
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL mid_frame_81 c=%0d: serial/done/busy=%b required %b", c, obs, exp);
            end
            if (c == 15) begin
                bus4.shift_out = 1'b0;
                bus4.out_byte  = 8'h00;
            end
        end
        n_checks++;
        if (ndone !== 1) begin
            n_fail++;
            $display("FAIL mid_frame_done_count: got %0d required 1", ndone);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [2:0] obs, exp;
        int ndone = 0;
        @(posedge clk); #1;
        bus4.shift_out = 1'b1;
        bus4.out_byte  = 8'h55;
        @(posedge clk); #1;
        bus4.shift_out = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            obs = {bus4.tx_serial, bus4.tx_done, bus4.tx_busy};
            exp = {exp_line(8'h55, c, 4), 1'b0, 1'b1};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL pre_reset_55 c=%0d: serial/done/busy=%b required %b", c, obs, exp);
            end
        end
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        obs = {bus4.tx_serial, bus4.tx_done, bus4.tx_busy};
        n_checks++;
        if (obs !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_async: serial/done/busy=%b required %b", obs, 3'b100);
        end
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            obs = {bus4.tx_serial, bus4.tx_done, bus4.tx_busy};
            if (obs[1]) ndone++;
            n_checks++;
            if (obs !== 3'b100) begin
                n_fail++;
                $display("FAIL post_reset_idle c=%0d: serial/done/busy=%b required %b", c, obs, 3'b100);
            end
        end
        n_checks++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL abandoned_done_count: got %0d required 0", ndone);
        end
        ndone = 0;
        @(posedge clk); #1;
        bus4.shift_out = 1'b1;
        bus4.out_byte  = 8'h0F;
        @(posedge clk); #1;
        bus4.shift_out = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            obs = {bus4.tx_serial, bus4.tx_done, bus4.tx_busy};
            exp = {exp_line(8'h0F, c, 4), 1'(c == 41), 1'(c <= 42)};
            if (obs[1]) ndone++;
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL after_reset_0f c=%0d: serial/done/busy=%b required %b", c, obs, exp);
            end
        end
        n_checks++;
        if (ndone !== 1) begin
            n_fail++;
            $display("FAIL after_reset_done_count: got %0d required 1", ndone);
        end
    endtask

    task automatic test_baud_scaling();
        logic [2:0] obs, exp;
        int ndone = 0;
        @(posedge clk); #1;
        bus434.shift_out = 1'b1;
        bus434.out_byte  = 8'h41;
        @(posedge clk); #1;
        bus434.shift_out = 1'b0;
        for (int c = 1; c <= 4345; c++) begin
            @(negedge clk);
            obs = {bus434.tx_serial, bus434.tx_done, bus434.tx_busy};
            exp = {exp_line(8'h41, c, 434), 1'(c == 4341), 1'(c <= 4342)};
            if (obs[1]) ndone++;
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL baud434_41 c=%0d: serial/done/busy=%b required %b", c, obs, exp);
            end
        end
        n_checks++;
        if (ndone !== 1) begin
            n_fail++;
            $display("FAIL baud434_done_count: got %0d required 1", ndone);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_held_request();
        test_mid_frame_inputs();
        test_reset_mid_frame();
        test_baud_scaling();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
